// File: rtl/agu_queue_pkg.sv
// Shared types for the load/store address-generation queue.
//   ROB_IDX_LEN / BR_CNT_LEN : widths of ROB tags and unresolved-branch counts
//   mem_op_t / funct3_t      : memory op kind and access width/sign
//   agu_entry_t              : op as delivered by dispatch (pending operands
//                              carry their ROB tag in the low bits of val1/val2)
//   address_buffer_element_t : op as handed to the memory address buffer
package agu_queue_pkg;

  localparam int ROB_IDX_LEN = 4;
  localparam int BR_CNT_LEN  = 4;

  typedef enum logic {
    ld = 1'b0,
    st = 1'b1
  } mem_op_t;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_t;

  typedef struct packed {
    logic [31:0]            val1;
    logic [31:0]            val2;
    logic [31:0]            imm;
    logic                   CB1;
    logic                   CB2;
    mem_op_t                mem_op;
    funct3_t                funct_3;
    logic [ROB_IDX_LEN-1:0] ROB_dest;
    logic [BR_CNT_LEN-1:0]  BR_cnt;
  } agu_entry_t;

  typedef struct packed {
    logic [31:0]            addr;
    logic [31:0]            data;
    mem_op_t                mem_op;
    funct3_t                funct_3;
    logic [ROB_IDX_LEN-1:0] ROB_dest;
  } address_buffer_element_t;

  // Effective address: 32-bit wrap-around sum, carry dropped.
  function automatic logic [31:0] agu_addr(input logic [31:0] base,
                                           input logic [31:0] imm);
    return base + imm;
  endfunction

endpackage

// File: rtl/agu_queue_cdb_snoop.sv
// Compares one pending operand against all CDB lanes.
//   pend_i/tag_i/val_i : operand state (tag valid only while pend_i is set)
//   cdb_*_i            : flattened broadcast lanes
//   val_o/pend_o       : operand after this cycle's broadcast
// When several lanes match, the highest lane index wins.
module cdb_snoop #(
  parameter int NUM_LANES   = 4,
  parameter int ROB_IDX_LEN = 4
) (
  input  logic                             pend_i,
  input  logic [ROB_IDX_LEN-1:0]           tag_i,
  input  logic [31:0]                      val_i,
  input  logic [NUM_LANES-1:0]             cdb_vld_i,
  input  logic [NUM_LANES*ROB_IDX_LEN-1:0] cdb_rob_i,
  input  logic [NUM_LANES*32-1:0]          cdb_data_i,
  output logic [31:0]                      val_o,
  output logic                             pend_o
);

  always_comb begin
    val_o  = val_i;
    pend_o = pend_i;
    for (int l = 0; l < NUM_LANES; l++) begin
      if (pend_i && cdb_vld_i[l] &&
          cdb_rob_i[l*ROB_IDX_LEN +: ROB_IDX_LEN] == tag_i) begin
        val_o  = cdb_data_i[l*32 +: 32];
        pend_o = 1'b0;
      end
    end
  end

endmodule

// File: rtl/agu_queue.sv
// In-order load/store address-generation queue.
//   clk, rst           : clock, synchronous active-high reset
//   flush_i            : empty the queue (same priority as rst)
//   br_commit_i        : oldest unresolved branch resolved correctly
//   br_squash_i        : oldest unresolved branch mispredicted
//   cdb_vld/rob/data_i : result broadcast lanes
//   vld_i/rdy_i/entry_i: enqueue handshake from dispatch
//   vld_o/rdy_o/data_o : issue handshake toward the address buffer
//   count_o            : occupied entries
// Ops wait for operands and for speculation to clear, then leave in program
// order with addr = val1 + imm.
module agu_queue
  import agu_queue_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int NUM_LANES   = 4,
  parameter int ROB_IDX_LEN = 4,
  parameter int BR_CNT_LEN  = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush_i,
  input  logic                             br_commit_i,
  input  logic                             br_squash_i,
  input  logic [NUM_LANES-1:0]             cdb_vld_i,
  input  logic [NUM_LANES*ROB_IDX_LEN-1:0] cdb_rob_i,
  input  logic [NUM_LANES*32-1:0]          cdb_data_i,
  input  logic                             vld_i,
  output logic                             rdy_i,
  input  agu_entry_t                       entry_i,
  output logic                             vld_o,
  input  logic                             rdy_o,
  output address_buffer_element_t          data_o,
  output logic [$clog2(DEPTH+1)-1:0]       count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  agu_entry_t       entry_q [DEPTH];
  agu_entry_t       entry_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [31:0]      snp_val1 [DEPTH];
  logic [31:0]      snp_val2 [DEPTH];
  logic             snp_cb1  [DEPTH];
  logic             snp_cb2  [DEPTH];
  logic [31:0]      enq_val1, enq_val2;
  logic             enq_cb1, enq_cb2;

  agu_entry_t       head;
  agu_entry_t       enq_entry;
  logic             enq, deq;

  // Pointer advance modulo DEPTH; DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p,
                                               input logic [CNT_W-1:0] n);
    int s;
    s = int'(p) + int'(n);
    if (s >= DEPTH) s = s - DEPTH;
    return PTR_W'(s);
  endfunction

  // Slot idx holds a live entry when its distance from the head is < count.
  function automatic logic is_occupied(input int idx, input int rd, input int cnt);
    int off;
    off = idx - rd;
    if (off < 0) off = off + DEPTH;
    return off < cnt;
  endfunction

  // Operand capture for resident entries.
  for (genvar i = 0; i < DEPTH; i++) begin : g_snoop
    cdb_snoop #(
      .NUM_LANES  (NUM_LANES),
      .ROB_IDX_LEN(ROB_IDX_LEN)
    ) u_snp1 (
      .pend_i    (entry_q[i].CB1),
      .tag_i     (entry_q[i].val1[ROB_IDX_LEN-1:0]),
      .val_i     (entry_q[i].val1),
      .cdb_vld_i (cdb_vld_i),
      .cdb_rob_i (cdb_rob_i),
      .cdb_data_i(cdb_data_i),
      .val_o     (snp_val1[i]),
      .pend_o    (snp_cb1[i])
    );
    cdb_snoop #(
      .NUM_LANES  (NUM_LANES),
      .ROB_IDX_LEN(ROB_IDX_LEN)
    ) u_snp2 (
      .pend_i    (entry_q[i].CB2),
      .tag_i     (entry_q[i].val2[ROB_IDX_LEN-1:0]),
      .val_i     (entry_q[i].val2),
      .cdb_vld_i (cdb_vld_i),
      .cdb_rob_i (cdb_rob_i),
      .cdb_data_i(cdb_data_i),
      .val_o     (snp_val2[i]),
      .pend_o    (snp_cb2[i])
    );
  end

  // Operand capture on the enqueue path, so a result broadcast in the
  // enqueue cycle is not missed.
  cdb_snoop #(
    .NUM_LANES  (NUM_LANES),
    .ROB_IDX_LEN(ROB_IDX_LEN)
  ) u_snp_enq1 (
    .pend_i    (entry_i.CB1),
    .tag_i     (entry_i.val1[ROB_IDX_LEN-1:0]),
    .val_i     (entry_i.val1),
    .cdb_vld_i (cdb_vld_i),
    .cdb_rob_i (cdb_rob_i),
    .cdb_data_i(cdb_data_i),
    .val_o     (enq_val1),
    .pend_o    (enq_cb1)
  );

  cdb_snoop #(
    .NUM_LANES  (NUM_LANES),
    .ROB_IDX_LEN(ROB_IDX_LEN)
  ) u_snp_enq2 (
    .pend_i    (entry_i.CB2),
    .tag_i     (entry_i.val2[ROB_IDX_LEN-1:0]),
    .val_i     (entry_i.val2),
    .cdb_vld_i (cdb_vld_i),
    .cdb_rob_i (cdb_rob_i),
    .cdb_data_i(cdb_data_i),
    .val_o     (enq_val2),
    .pend_o    (enq_cb2)
  );

  assign head    = entry_q[rd_ptr_q];
  assign rdy_i   = (count_q < CNT_W'(DEPTH));
  assign count_o = count_q;

  // A head whose only outstanding branch resolves this cycle may issue now.
  always_comb begin
    vld_o = (count_q != '0) && !head.CB1 && (head.mem_op == ld || !head.CB2) &&
            (head.BR_cnt == '0 || (head.BR_cnt == BR_CNT_LEN'(1) && br_commit_i));
  end

  always_comb begin
    data_o.addr     = agu_addr(head.val1, head.imm);
    data_o.data     = head.val2;
    data_o.mem_op   = head.mem_op;
    data_o.funct_3  = head.funct_3;
    data_o.ROB_dest = head.ROB_dest;
  end

  assign enq = vld_i && rdy_i && !br_squash_i && !flush_i;
  assign deq = vld_o && rdy_o;

  always_comb begin
    enq_entry      = entry_i;
    enq_entry.val1 = enq_val1;
    enq_entry.CB1  = enq_cb1;
    enq_entry.val2 = enq_val2;
    enq_entry.CB2  = enq_cb2;
    if (br_commit_i && enq_entry.BR_cnt != '0)
      enq_entry.BR_cnt = enq_entry.BR_cnt - BR_CNT_LEN'(1);
  end

  always_comb begin : next_state
    int kept_n;
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    kept_n   = 0;

    // Free slots may also be updated here; they are overwritten on enqueue.
    for (int i = 0; i < DEPTH; i++) begin
      entry_d[i].val1 = snp_val1[i];
      entry_d[i].CB1  = snp_cb1[i];
      entry_d[i].val2 = snp_val2[i];
      entry_d[i].CB2  = snp_cb2[i];
      if (br_commit_i && entry_d[i].BR_cnt != '0)
        entry_d[i].BR_cnt = entry_d[i].BR_cnt - BR_CNT_LEN'(1);
    end

    if (enq) entry_d[wr_ptr_q] = enq_entry;

    if (deq) rd_ptr_d = ptr_add(rd_ptr_q, CNT_W'(1));

    if (br_squash_i) begin
      // BR_cnt never decreases toward the tail, so the survivors are a
      // contiguous run starting at the head.
      for (int i = 0; i < DEPTH; i++) begin
        if (is_occupied(i, int'(rd_ptr_q), int'(count_q)) && entry_q[i].BR_cnt == '0)
          kept_n++;
      end
      if (deq) kept_n--;
      count_d  = CNT_W'(kept_n);
      wr_ptr_d = ptr_add(rd_ptr_d, CNT_W'(kept_n));
    end else begin
      if (enq) wr_ptr_d = ptr_add(wr_ptr_q, CNT_W'(1));
      count_d = count_q + CNT_W'(enq) - CNT_W'(deq);
    end

    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload needs no reset: occupancy is defined by count/rd_ptr alone.
  always_ff @(posedge clk) begin
    entry_q <= entry_d;
  end

  a_no_commit_and_squash: assert property (@(posedge clk) disable iff (rst)
    !(br_commit_i && br_squash_i));

endmodule

// File: tb/tb_agu_queue.sv
module tb_agu_queue;
  import agu_queue_pkg::*;

  localparam int DEPTH = 5;
  localparam int NL    = 4;
  localparam int RL    = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, flush_i, br_commit_i, br_squash_i;
  logic [NL-1:0]        cdb_vld;
  logic [NL*RL-1:0]     cdb_rob;
  logic [NL*32-1:0]     cdb_data;
  logic                 vld_i, rdy_i, vld_o, rdy_o;
  agu_entry_t           ent;
  address_buffer_element_t dout;
  logic [2:0]           count_o;

  int checks = 0;
  int errors = 0;
  int nb;
  agu_entry_t mq[$];

  agu_queue #(
    .DEPTH(DEPTH), .NUM_LANES(NL), .ROB_IDX_LEN(RL), .BR_CNT_LEN(4)
  ) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .br_commit_i(br_commit_i), .br_squash_i(br_squash_i),
    .cdb_vld_i(cdb_vld), .cdb_rob_i(cdb_rob), .cdb_data_i(cdb_data),
    .vld_i(vld_i), .rdy_i(rdy_i), .entry_i(ent),
    .vld_o(vld_o), .rdy_o(rdy_o), .data_o(dout), .count_o(count_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic agu_entry_t mk(input logic [31:0] v1, input logic [31:0] v2,
                                    input logic [31:0] imm, input logic cb1,
                                    input logic cb2, input logic is_st,
                                    input logic [3:0] br, input logic [3:0] rob);
    agu_entry_t e;
    e.val1 = v1; e.val2 = v2; e.imm = imm;
    e.CB1 = cb1; e.CB2 = cb2;
    e.mem_op = is_st ? st : ld;
    e.funct_3 = F3_W;
    e.ROB_dest = rob;
    e.BR_cnt = br;
    return e;
  endfunction

  task automatic idle();
    rst = 1'b0; flush_i = 1'b0; br_commit_i = 1'b0; br_squash_i = 1'b0;
    cdb_vld = '0; cdb_rob = '0; cdb_data = '0;
    vld_i = 1'b0; rdy_o = 1'b0;
    ent = mk(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
  endtask

  task automatic set_lane(input int l, input logic [3:0] tag, input logic [31:0] d);
    cdb_vld[l] = 1'b1;
    cdb_rob[l*RL +: RL] = tag;
    cdb_data[l*32 +: 32] = d;
  endtask

  // Reference: highest-numbered matching lane supplies the value.
  function automatic bit lane_hit(input logic [3:0] tag, output logic [31:0] d);
    int n;
    bit found;
    n = 0; found = 0; d = '0;
    for (int l = NL-1; l >= 0; l--) begin
      if (cdb_vld[l] && cdb_rob[l*RL +: RL] == tag) begin
        n++;
        if (!found) begin d = cdb_data[l*32 +: 32]; found = 1; end
      end
    end
    if (n > 1) begin
      errors++;
      $display("FAIL multi_lane_match tag=%0h lanes=%0d required=1", tag, n);
    end
    return found;
  endfunction

  function automatic agu_entry_t snoop(input agu_entry_t e);
    logic [31:0] d;
    if (e.CB1 && lane_hit(e.val1[3:0], d)) begin e.val1 = d; e.CB1 = 1'b0; end
    if (e.CB2 && lane_hit(e.val2[3:0], d)) begin e.val2 = d; e.CB2 = 1'b0; end
    return e;
  endfunction

  function automatic bit head_ok();
    agu_entry_t h;
    if (mq.size() == 0) return 1'b0;
    h = mq[0];
    return !h.CB1 && (h.mem_op == ld || !h.CB2) &&
           (h.BR_cnt == 4'd0 || (h.BR_cnt == 4'd1 && br_commit_i));
  endfunction

  task automatic model_check();
    bit hv;
    agu_entry_t h;
    hv = head_ok();
    chk("rdy_i", 32'(rdy_i), 32'(mq.size() < DEPTH));
    chk("count_o", 32'(count_o), 32'(mq.size()));
    chk("vld_o", 32'(vld_o), 32'(hv));
    if (hv) begin
      h = mq[0];
      chk("addr", dout.addr, h.val1 + h.imm);
      chk("data", dout.data, h.val2);
      chk("rob_dest", 32'(dout.ROB_dest), 32'(h.ROB_dest));
      chk("mem_op", 32'(dout.mem_op), 32'(h.mem_op));
      chk("funct_3", 32'(dout.funct_3), 32'(h.funct_3));
    end
  endtask

  task automatic model_step();
    bit deq, enq;
    agu_entry_t e;
    agu_entry_t nq[$];
    if (rst || flush_i) begin mq.delete(); return; end
    deq = head_ok() && rdy_o;
    enq = vld_i && (mq.size() < DEPTH) && !br_squash_i;
    e = snoop(ent);
    if (br_commit_i && e.BR_cnt != 4'd0) e.BR_cnt = e.BR_cnt - 4'd1;
    foreach (mq[i]) mq[i] = snoop(mq[i]);
    if (deq) void'(mq.pop_front());
    if (br_squash_i) begin
      foreach (mq[i]) if (mq[i].BR_cnt == 4'd0) nq.push_back(mq[i]);
      mq = nq;
    end else begin
      if (br_commit_i)
        foreach (mq[i]) if (mq[i].BR_cnt != 4'd0) mq[i].BR_cnt = mq[i].BR_cnt - 4'd1;
      if (enq) mq.push_back(e);
    end
  endtask

  task automatic cycle();
    #1;
    model_check();
    model_step();
    @(negedge clk);
  endtask

  initial begin
    int base;
    logic [3:0] brs [4];
    idle();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    idle();
    #1;
    chk("reset_count", 32'(count_o), 32'd0);
    chk("reset_vld", 32'(vld_o), 32'd0);
    chk("reset_rdy", 32'(rdy_i), 32'd1);

    // Capacity and wrap
    for (int k = 0; k < 5; k++) begin
      idle(); vld_i = 1'b1;
      ent = mk(32'h100, 32'd0, 32'(4*k), 1'b0, 1'b0, 1'b0, 4'd0, 4'(k));
      cycle();
    end
    idle(); #1;
    chk("full_rdy", 32'(rdy_i), 32'd0);
    chk("full_count", 32'(count_o), 32'd5);
    for (int k = 0; k < 5; k++) begin
      idle(); rdy_o = 1'b1;
      if (k == 0) begin
        vld_i = 1'b1;
        ent = mk(32'h999, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
      end
      #1;
      chk("drain_addr", dout.addr, 32'h100 + 32'(4*k));
      chk("drain_count", 32'(count_o), 32'(5-k));
      cycle();
    end
    idle(); #1; chk("drained_count", 32'(count_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      idle(); vld_i = 1'b1;
      ent = mk(32'h200, 32'd0, 32'(k), 1'b0, 1'b0, 1'b0, 4'd0, 4'(k));
      cycle();
    end
    for (int k = 0; k < 3; k++) begin
      idle(); rdy_o = 1'b1; #1;
      chk("wrap_addr", dout.addr, 32'h200 + 32'(k));
      cycle();
    end

    // CDB capture on resident entry
    idle(); vld_i = 1'b1;
    ent = mk(32'd3, 32'd5, 32'h10, 1'b1, 1'b1, 1'b1, 4'd0, 4'd9);
    cycle();
    idle(); set_lane(2, 4'd3, 32'h2000); #1;
    chk("cdb_wait1", 32'(vld_o), 32'd0);
    cycle();
    idle(); set_lane(0, 4'd5, 32'hDEAD); #1;
    chk("cdb_wait2", 32'(vld_o), 32'd0);
    cycle();
    idle(); rdy_o = 1'b1; #1;
    chk("cdb_vld", 32'(vld_o), 32'd1);
    chk("cdb_addr", dout.addr, 32'h2010);
    chk("cdb_data", dout.data, 32'hDEAD);
    cycle();

    // Enqueue-cycle capture
    idle(); vld_i = 1'b1;
    ent = mk(32'd7, 32'd0, 32'd8, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1);
    set_lane(1, 4'd7, 32'h40);
    cycle();
    idle(); rdy_o = 1'b1; #1;
    chk("enq_cap_vld", 32'(vld_o), 32'd1);
    chk("enq_cap_addr", dout.addr, 32'h48);
    cycle();

    // Speculation
    idle(); vld_i = 1'b1;
    ent = mk(32'h500, 32'd0, 32'd4, 1'b0, 1'b0, 1'b0, 4'd1, 4'd2);
    cycle();
    idle(); rdy_o = 1'b1; #1;
    chk("spec_blocked", 32'(vld_o), 32'd0);
    cycle();
    idle(); br_commit_i = 1'b1; rdy_o = 1'b1; #1;
    chk("spec_commit_vld", 32'(vld_o), 32'd1);
    chk("spec_commit_addr", dout.addr, 32'h504);
    cycle();
    idle(); #1; chk("spec_count", 32'(count_o), 32'd0);

    // Squash
    brs[0] = 4'd0; brs[1] = 4'd0; brs[2] = 4'd1; brs[3] = 4'd2;
    for (int k = 0; k < 4; k++) begin
      idle(); vld_i = 1'b1;
      ent = mk(32'h600 + 32'(16*k), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, brs[k], 4'(k));
      cycle();
    end
    idle(); br_squash_i = 1'b1; vld_i = 1'b1;
    ent = mk(32'h6F0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0);
    cycle();
    idle(); #1; chk("squash_count", 32'(count_o), 32'd2);
    vld_i = 1'b1;
    ent = mk(32'h700, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd5);
    cycle();
    for (int k = 0; k < 3; k++) begin
      idle(); rdy_o = 1'b1; #1;
      chk("squash_order", dout.addr, (k == 2) ? 32'h700 : 32'h600 + 32'(16*k));
      cycle();
    end

    // Flush and reset mid-stream
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        idle(); vld_i = 1'b1;
        ent = mk(32'h800, 32'd0, 32'(k), 1'b0, 1'b0, 1'b0, 4'd0, 4'(k));
        cycle();
      end
      idle(); #1;
      chk("pre_clear_vld", 32'(vld_o), 32'd1);
      if (r == 0) flush_i = 1'b1; else rst = 1'b1;
      vld_i = 1'b1; rdy_o = 1'b1;
      cycle();
      idle(); #1;
      chk("clear_count", 32'(count_o), 32'd0);
      chk("clear_vld", 32'(vld_o), 32'd0);
      chk("clear_rdy", 32'(rdy_i), 32'd1);
      cycle();
    end

    // Randomized traffic
    nb = 0;
    for (int c = 0; c < 3000; c++) begin
      int r;
      idle();
      r = int'($urandom % 100);
      if (r < 2) flush_i = 1'b1;
      else if (r < 3) rst = 1'b1;
      else if (nb > 0 && r < 12) br_commit_i = 1'b1;
      else if (nb > 0 && r < 15) br_squash_i = 1'b1;
      base = int'($urandom % 16);
      for (int l = 0; l < NL; l++) begin
        cdb_vld[l] = ($urandom % 3 == 0);
        cdb_rob[l*RL +: RL] = 4'((base + l) % 16);
        cdb_data[l*32 +: 32] = $urandom;
      end
      vld_i = ($urandom % 100 < 60);
      ent = mk($urandom, $urandom, $urandom, 1'($urandom % 2), 1'($urandom % 2),
               1'($urandom % 2), 4'(nb), 4'($urandom % 16));
      ent.funct_3 = ($urandom % 2 == 0) ? F3_BU : F3_H;
      rdy_o = ($urandom % 100 < 70);
      cycle();
      if (rst || flush_i || br_squash_i) nb = 0;
      else if (br_commit_i) nb = nb - 1;
      if (nb < 3 && $urandom % 10 == 0) nb = nb + 1;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
